// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Operands and results move over valid/ready handshakes; borrow is registered.
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_nx;
   logic [CW-1:0]    cnt;
   logic             a_i;
   logic             b_i;
   logic             d_i;
   logic             br_nx;

   // The borrow output register doubles as the running borrow.
   always_comb begin
      a_i     = a_sr[0];
      b_i     = b_sr[0];
      d_i     = a_i ^ b_i ^ borrow;
      br_nx   = (~a_i & b_i) | (~(a_i ^ b_i) & borrow);
      diff_nx = diff >> 1;
      diff_nx[WIDTH-1] = d_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         diff      <= '0;
         borrow    <= 1'b0;
         cnt       <= '0;
         a_sr      <= '0;
         b_sr      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr     <= a;
                  b_sr     <= b;
                  borrow   <= 1'b0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               diff   <= diff_nx;
               borrow <= br_nx;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Directed-vector bench for serial_sub: WIDTH=8 and WIDTH=1 instances.
// Expected values are hand-computed constants.
module tb_serial_sub;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] diff;
   logic       borrow;

   logic       iv1 = 1'b0;
   logic       ir1;
   logic [0:0] a1 = '0;
   logic [0:0] b1 = '0;
   logic       ov1;
   logic       or1 = 1'b1;
   logic [0:0] d1;
   logic       br1;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       br;
   } vec_t;

   typedef struct {
      logic a;
      logic b;
      logic d;
      logic br;
   } vec1_t;

   vec_t  tv[8];
   vec_t  bb[4];
   vec1_t tv1[4];

   serial_sub #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .borrow(borrow)
   );

   serial_sub #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1),
      .out_valid(ov1), .out_ready(or1),
      .diff(d1), .borrow(br1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller sits #1 after an edge with the WIDTH=8 DUT idle.
   task automatic wait_out(input string nm, input int lat);
      int n;
      n = 0;
      while (!out_valid && n < 30) begin
         tick();
         n++;
      end
      chk({nm, "_lat"}, n, lat);
   endtask

   task automatic op8(input string nm, input vec_t v);
      a = v.a;
      b = v.b;
      in_valid = 1'b1;
      chk({nm, "_in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      wait_out(nm, 8);
      chk({nm, "_diff"}, diff, v.d);
      chk({nm, "_borrow"}, borrow, v.br);
      tick();
      chk({nm, "_rdy_after"}, in_ready, 1);
      chk({nm, "_ov_after"}, out_valid, 0);
   endtask

   task automatic op1(input string nm, input vec1_t v);
      int n;
      a1 = v.a;
      b1 = v.b;
      iv1 = 1'b1;
      tick();
      iv1 = 1'b0;
      n = 0;
      while (!ov1 && n < 10) begin
         tick();
         n++;
      end
      chk({nm, "_lat"}, n, 1);
      chk({nm, "_diff"}, d1, v.d);
      chk({nm, "_borrow"}, br1, v.br);
      tick();
      chk({nm, "_rdy_after"}, ir1, 1);
   endtask

   initial begin
      int t_prev;
      int t_acc;
      int n;

      tv[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
      tv[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
      tv[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
      tv[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
      tv[4] = '{8'h80, 8'h7F, 8'h01, 1'b0};
      tv[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
      tv[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
      tv[7] = '{8'hFF, 8'h00, 8'hFF, 1'b0};

      bb[0] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};
      bb[1] = '{8'h12, 8'h34, 8'hDE, 1'b1};
      bb[2] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
      bb[3] = '{8'h01, 8'h02, 8'hFF, 1'b1};

      tv1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      tv1[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
      tv1[2] = '{1'b0, 1'b1, 1'b1, 1'b1};
      tv1[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

      // reset state
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow, 0);
      chk("rst1_in_ready", ir1, 1);
      chk("rst1_out_valid", ov1, 0);

      // table vectors
      for (int i = 0; i < 8; i++)
         op8($sformatf("vec%0d", i), tv[i]);

      // backpressure
      out_ready = 1'b0;
      a = 8'h80;
      b = 8'h01;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_out("bp", 8);
      for (int i = 0; i < 5; i++) begin
         a = 8'h11 + 8'(i);
         b = 8'h22;
         in_valid = 1'b1;
         chk($sformatf("bp_diff%0d", i), diff, 8'h7F);
         chk($sformatf("bp_borrow%0d", i), borrow, 0);
         chk($sformatf("bp_in_ready%0d", i), in_ready, 0);
         chk($sformatf("bp_ov%0d", i), out_valid, 1);
         tick();
      end
      chk("bp_diff_hold", diff, 8'h7F);
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_rdy", in_ready, 1);
      chk("bp_release_ov", out_valid, 0);

      // reset during the third RUN cycle
      a = 8'h00;
      b = 8'h01;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_ov", out_valid, 0);
      chk("mid_rst_borrow", borrow, 0);
      op8("post_rst", '{8'h10, 8'h10, 8'h00, 1'b0});

      // back-to-back with in_valid held high
      a = bb[0].a;
      b = bb[0].b;
      in_valid = 1'b1;
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!in_ready && n < 30) begin
            tick();
            n++;
         end
         chk($sformatf("b2b%0d_in_ready", i), in_ready, 1);
         tick();
         t_acc = cyc;
         if (i < 3) begin
            a = bb[i+1].a;
            b = bb[i+1].b;
         end
         wait_out($sformatf("b2b%0d", i), 8);
         chk($sformatf("b2b%0d_diff", i), diff, bb[i].d);
         chk($sformatf("b2b%0d_borrow", i), borrow, bb[i].br);
         if (i > 0)
            chk($sformatf("b2b%0d_ii", i), t_acc - t_prev, 10);
         t_prev = t_acc;
      end
      in_valid = 1'b0;
      tick();

      // WIDTH=1 instance
      for (int i = 0; i < 4; i++)
         op1($sformatf("w1_%0d", i), tv1[i]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial unsigned subtractor: the difference/borrow counterpart of the team's combinational half adder (`add`).
- Accepts two WIDTH-bit operands through a valid/ready handshake and processes them LSB-first, one bit per clock, with a registered borrow.
- Returns the difference and a borrow-out through a second valid/ready handshake.
- Intended as the area-minimal subtract path beside the adder cells in arithmetic datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend (unsigned).
- b  input  WIDTH  subtrahend (unsigned).
- out_valid  output  1  diff/borrow are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow  output  1  1 iff a < b (unsigned).

Behaviour:
- Reset: rst sampled high at an edge forces state IDLE. After that edge: in_ready=1, out_valid=0, diff=0, borrow=0, bit counter=0, operand shift registers=0. rst has priority over every other input.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch a and b into shift registers, clear the internal borrow and the counter, go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0, out_valid=0. One bit is processed per edge, using a_i = a_sr[0], b_i = b_sr[0], br = borrow register.
  - d_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i shifts into diff from the MSB side. a_sr and b_sr shift right. The counter increments.
  - After the WIDTH-th RUN edge, go to DONE.
  - The counter is $clog2(WIDTH+1) bits wide and has no wrap-around.
- DONE:
  - out_valid=1, in_ready=0. diff holds the full result and borrow holds the final br.
  - diff and borrow stay stable while out_ready=0; backpressure is unbounded.
  - On an edge with out_ready=1, go to IDLE. Same-edge acceptance of a new operand is not allowed.
- Latency: out_valid is high in the cycle following the WIDTH-th edge after the accepting edge, i.e. WIDTH cycles after acceptance. Minimum initiation interval is WIDTH+2 cycles (with out_ready held high).
- Input changes: a/b/in_valid changes during RUN or DONE are ignored.
- Output stability: diff and borrow are only guaranteed meaningful while out_valid=1. They may change freely during RUN.
- WIDTH=1: one RUN cycle; the block behaves as a registered half subtractor.
- Reset mid-operation: rst in RUN or DONE aborts at that edge. The partial result is discarded, out_valid drops, and the next operation starts from a cleared borrow.

Test Plan (WIDTH=8):
1. a=0x05, b=0x03, in_valid pulse, out_ready=1 -> out_valid exactly 8 cycles after the accept edge, diff=0x02, borrow=0; in_ready returns high the cycle after the output handshake.
2. a=0x03, b=0x05 -> diff=0xFE, borrow=1. Then a=0x00, b=0xFF -> diff=0x01, borrow=1. Then a=0xFF, b=0xFF -> diff=0x00, borrow=0. Together these check borrow propagation through all bits.
3. Backpressure: a=0x80, b=0x01 with out_ready=0 for 5 cycles after out_valid -> diff=0x7F, borrow=0 held constant; in_ready=0 throughout; new a/b with in_valid=1 during the wait are ignored; the result is consumed on out_ready=1.
4. Reset mid-RUN: accept a=0x00, b=0x01, assert rst for 1 cycle at the 3rd RUN cycle -> next cycle in_ready=1, out_valid=0, borrow=0; the following op a=0x10, b=0x10 gives diff=0x00, borrow=0 with no stale borrow.
5. Back-to-back: in_valid held high with 4 random operand pairs, out_ready=1 -> each result is correct against a - b reference, and the initiation interval is exactly 10 cycles.
6. WIDTH=1 instance: all four (a,b) combinations -> diff/borrow = 0/0, 1/0, 1/1, 0/0 for (0,0), (1,0), (0,1), (1,1); each has 1-cycle latency.
